// File: rtl/cp0_ctl_v2.sv
// CP0 state for the commit stage: Status/Cause/EPC/timer, plus TLB registers when CP0_TLB_EN is defined.
// MFC0 is combinational; every write lands on the next edge; no backpressure, one write source per cycle.
module cp0_ctl_v2 #(
    parameter int NUM_HW_INTR = 6,
    parameter int COUNT_DIV   = 2,
    parameter int TLB_ENTRIES = 16,
    localparam int IDX_W      = $clog2(TLB_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_HW_INTR-1:0] cp0_intr_i,
    input  logic [7:0]             cp0_addr_i,
    input  logic                   cp0_ren_i,
    input  logic                   cp0_wen_i,
    input  logic [31:0]            cp0_wdata_i,
    input  logic                   cp0_exc_flag_i,
    input  logic [3:0]             cp0_exc_type_i,
    input  logic [31:0]            cp0_pc_i,
    input  logic                   cp0_inslot_i,
    input  logic [31:0]            cp0_baddr_i,
    input  logic                   tlbp_wen_i,
    input  logic                   tlbp_miss_i,
    input  logic [IDX_W-1:0]       tlbp_idx_i,
    input  logic                   tlbr_wen_i,
    input  logic [31:0]            tlbr_hi_i,
    input  logic [31:0]            tlbr_lo0_i,
    input  logic [31:0]            tlbr_lo1_i,
    output logic [31:0]            cp0_rdata_o,
    output logic [31:0]            Status_o,
    output logic [31:0]            Cause_o,
    output logic [31:0]            EPC_o,
    output logic [31:0]            EntryHi_o,
    output logic [31:0]            Index_o,
    output logic [31:0]            Random_o,
    output logic                   exc_intr
);
    localparam logic [7:0] A_INDEX = 8'h00, A_RANDOM = 8'h08, A_LO0 = 8'h10, A_LO1 = 8'h18,
        A_CONTEXT = 8'h20, A_WIRED = 8'h30, A_BADV = 8'h40, A_COUNT = 8'h48, A_HI = 8'h50,
        A_COMPARE = 8'h58, A_STATUS = 8'h60, A_CAUSE = 8'h68, A_EPC = 8'h70, A_PRID = 8'h78,
        A_CONFIG = 8'h80, A_CONFIG1 = 8'h81, A_ERREPC = 8'hF0;
    localparam logic [3:0] T_INTR = 4'd0, T_ADEL1 = 4'd1, T_ADEL2 = 4'd2, T_ADES = 4'd3,
        T_OV = 4'd4, T_SYSC = 4'd5, T_BP = 4'd6, T_RI = 4'd7, T_TLBL = 4'd8, T_TLBS = 4'd9,
        T_TLBM = 4'd10, T_ERET = 4'd15;
    localparam logic [31:0] PRID = 32'h0001_8000;
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0] presc;
    logic [31:0]   count, compare, epc, badvaddr, error_epc;
    logic          bev, exl, ie, bd, ti;
    logic [7:0]    im, ip_eff;
    logic [5:0]    ip_hw, intr_ext;
    logic [1:0]    ip_sw;
    logic [4:0]    exc_code, exc_code_n;
    logic [2:0]    k0;
    logic          tlb_act, mtc0, presc_wrap, is_tlb_exc, is_addr_exc;
    logic [31:0]   lo0_r, lo1_r, ctx_r, wired_r;
    logic [5:0]    mmu_size;

    always_comb begin
        intr_ext = '0;
        intr_ext[NUM_HW_INTR-1:0] = cp0_intr_i;
    end

    always_comb begin
        exc_code_n = 5'd10;
        case (cp0_exc_type_i)
            T_INTR:          exc_code_n = 5'd0;
            T_ADEL1, T_ADEL2: exc_code_n = 5'd4;
            T_ADES:          exc_code_n = 5'd5;
            T_OV:            exc_code_n = 5'd12;
            T_SYSC:          exc_code_n = 5'd8;
            T_BP:            exc_code_n = 5'd9;
            T_RI:            exc_code_n = 5'd10;
            T_TLBL:          exc_code_n = 5'd2;
            T_TLBS:          exc_code_n = 5'd3;
            T_TLBM:          exc_code_n = 5'd1;
            default:         exc_code_n = 5'd10;
        endcase
    end

    assign is_tlb_exc  = (cp0_exc_type_i == T_TLBL) || (cp0_exc_type_i == T_TLBS) ||
                         (cp0_exc_type_i == T_TLBM);
    assign is_addr_exc = (cp0_exc_type_i == T_ADEL1) || (cp0_exc_type_i == T_ADEL2) ||
                         (cp0_exc_type_i == T_ADES);
    // Exceptions beat TLB results, which beat MTC0; the loser is simply dropped.
    assign mtc0        = cp0_wen_i & ~cp0_exc_flag_i & ~tlb_act;
    assign presc_wrap  = (presc == PW'(COUNT_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;  count <= '0;  compare <= '0;  epc <= '0;  badvaddr <= '0;
            error_epc <= 32'hBFC0_0000;
            bev <= 1'b1;  exl <= 1'b0;  ie <= 1'b0;  bd <= 1'b0;  ti <= 1'b0;
            im <= '0;  ip_hw <= '0;  ip_sw <= '0;  exc_code <= '0;  k0 <= 3'd3;
        end else begin
            ip_hw <= intr_ext;
            presc <= presc_wrap ? '0 : presc + PW'(1);
            if (presc_wrap)
                count <= count + 32'd1;
            if ((count == compare) && (compare != 32'd0))
                ti <= 1'b1;
            if (cp0_exc_flag_i) begin
                if (cp0_exc_type_i == T_ERET) begin
                    exl <= 1'b0;
                end else begin
                    if (!exl) begin
                        epc <= cp0_inslot_i ? cp0_pc_i - 32'd4 : cp0_pc_i;
                        bd  <= cp0_inslot_i;
                    end
                    exl      <= 1'b1;
                    exc_code <= exc_code_n;
                    if (is_addr_exc || is_tlb_exc)
                        badvaddr <= cp0_baddr_i;
                end
            end else if (mtc0) begin
                case (cp0_addr_i)
                    A_COUNT:   begin count <= cp0_wdata_i; presc <= '0; end
                    A_COMPARE: begin compare <= cp0_wdata_i; ti <= 1'b0; end
                    A_STATUS:  begin
                        bev <= cp0_wdata_i[22];  im <= cp0_wdata_i[15:8];
                        exl <= cp0_wdata_i[1];   ie <= cp0_wdata_i[0];
                    end
                    A_CAUSE:   ip_sw <= cp0_wdata_i[9:8];
                    A_EPC:     epc <= cp0_wdata_i;
                    A_CONFIG:  k0 <= cp0_wdata_i[2:0];
                    A_ERREPC:  error_epc <= cp0_wdata_i;
                    default:   ;
                endcase
            end
        end
    end

`ifdef CP0_TLB_EN
    localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(TLB_ENTRIES - 1);
    logic             index_p;
    logic [IDX_W-1:0] index_i, random;
    logic [IDX_W:0]   wired;
    logic [18:0]      hi_vpn2, ctx_vpn2;
    logic [7:0]       hi_asid;
    logic [8:0]       ctx_pte;
    logic [25:0]      lo0, lo1;
    logic             unused_tlb_bits;

    assign unused_tlb_bits = ^{tlbr_hi_i[12:8], tlbr_lo0_i[31:26], tlbr_lo1_i[31:26]};
    assign tlb_act = tlbp_wen_i | tlbr_wen_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            index_p <= 1'b0;  index_i <= '0;  random <= RAND_MAX;  wired <= '0;
            hi_vpn2 <= '0;  hi_asid <= '0;  ctx_vpn2 <= '0;  ctx_pte <= '0;  lo0 <= '0;  lo1 <= '0;
        end else begin
            // Wired >= TLB_ENTRIES also lands here, so Random parks at its top value.
            if ({1'b0, random} <= wired)
                random <= RAND_MAX;
            else
                random <= random - IDX_W'(1);
            if (cp0_exc_flag_i) begin
                if (is_tlb_exc) begin
                    hi_vpn2  <= cp0_baddr_i[31:13];
                    ctx_vpn2 <= cp0_baddr_i[31:13];
                end
            end else if (tlb_act) begin
                if (tlbp_wen_i) begin
                    index_p <= tlbp_miss_i;
                    if (!tlbp_miss_i)
                        index_i <= tlbp_idx_i;
                end
                if (tlbr_wen_i) begin
                    hi_vpn2 <= tlbr_hi_i[31:13];  hi_asid <= tlbr_hi_i[7:0];
                    lo0 <= tlbr_lo0_i[25:0];      lo1 <= tlbr_lo1_i[25:0];
                end
            end else if (cp0_wen_i) begin
                case (cp0_addr_i)
                    A_INDEX:   index_i <= cp0_wdata_i[IDX_W-1:0];
                    A_LO0:     lo0 <= cp0_wdata_i[25:0];
                    A_LO1:     lo1 <= cp0_wdata_i[25:0];
                    A_CONTEXT: ctx_pte <= cp0_wdata_i[31:23];
                    A_HI:      begin hi_vpn2 <= cp0_wdata_i[31:13]; hi_asid <= cp0_wdata_i[7:0]; end
                    A_WIRED:   begin
                        wired  <= (cp0_wdata_i >= 32'(TLB_ENTRIES)) ? (IDX_W+1)'(TLB_ENTRIES)
                                                                     : cp0_wdata_i[IDX_W:0];
                        random <= RAND_MAX;
                    end
                    default:   ;
                endcase
            end
        end
    end

    assign Index_o   = {index_p, {(31-IDX_W){1'b0}}, index_i};
    assign Random_o  = 32'(random);
    assign EntryHi_o = {hi_vpn2, 5'b0, hi_asid};
    assign lo0_r     = 32'(lo0);
    assign lo1_r     = 32'(lo1);
    assign ctx_r     = {ctx_pte, ctx_vpn2, 4'b0};
    assign wired_r   = 32'(wired);
    assign mmu_size  = 6'(TLB_ENTRIES - 1);
`else
    logic unused_tlb;
    assign unused_tlb = ^{tlbp_wen_i, tlbp_miss_i, tlbp_idx_i, tlbr_wen_i, tlbr_hi_i,
                          tlbr_lo0_i, tlbr_lo1_i};
    assign tlb_act   = 1'b0;
    assign Index_o   = '0;
    assign Random_o  = '0;
    assign EntryHi_o = '0;
    assign lo0_r     = '0;
    assign lo1_r     = '0;
    assign ctx_r     = '0;
    assign wired_r   = '0;
    assign mmu_size  = '0;
`endif

    assign ip_eff   = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
    assign Status_o = {9'b0, bev, 6'b0, im, 6'b0, exl, ie};
    assign Cause_o  = {bd, ti, 14'b0, ip_eff, 1'b0, exc_code, 2'b0};
    assign EPC_o    = epc;
    assign exc_intr = (|(ip_eff & im)) & ie & ~exl;

    always_comb begin
        cp0_rdata_o = '0;
        if (cp0_ren_i) begin
            case (cp0_addr_i)
                A_INDEX:   cp0_rdata_o = Index_o;
                A_RANDOM:  cp0_rdata_o = Random_o;
                A_LO0:     cp0_rdata_o = lo0_r;
                A_LO1:     cp0_rdata_o = lo1_r;
                A_CONTEXT: cp0_rdata_o = ctx_r;
                A_WIRED:   cp0_rdata_o = wired_r;
                A_BADV:    cp0_rdata_o = badvaddr;
                A_COUNT:   cp0_rdata_o = count;
                A_HI:      cp0_rdata_o = EntryHi_o;
                A_COMPARE: cp0_rdata_o = compare;
                A_STATUS:  cp0_rdata_o = Status_o;
                A_CAUSE:   cp0_rdata_o = Cause_o;
                A_EPC:     cp0_rdata_o = epc;
                A_PRID:    cp0_rdata_o = PRID;
                A_CONFIG:  cp0_rdata_o = {1'b1, 21'b0, 3'b001, 4'b0, k0};
                A_CONFIG1: cp0_rdata_o = {1'b0, mmu_size, 25'b0};
                A_ERREPC:  cp0_rdata_o = error_epc;
                default:   cp0_rdata_o = '0;
            endcase
        end
    end
endmodule
